// File: rtl/mod_keygen_rotword_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_keygen_rotword_pipe
// Brief    : Key-expansion RotWord stage with its own word index, Rcon
//            generation and a 2-entry skid FIFO towards the S-box/Rcon stage.
//            Optional macro KEYGEN_ROTDIR_EN adds a per-word rot_dir input.
// Revision : 1.0 - initial release
// ============================================================================
module mod_keygen_rotword_pipe #(
    parameter int BYTES = 4,
    parameter int BW    = 8,
    parameter int NK    = 8,
    parameter int ROT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTES*BW-1:0]   in_word,
`ifdef KEYGEN_ROTDIR_EN
    input  logic                  rot_dir,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTES*BW-1:0]   out_word,
    output logic                  out_sub,
    output logic [7:0]            out_rcon,
    output logic                  out_last,
    output logic                  done
);

    localparam int c_W    = BYTES * BW;
    localparam int c_LAST = 4 * (NK + 7) - 1;
    localparam int c_IW   = $clog2(c_LAST + 2);
    localparam int c_MW   = $clog2(NK + 1);
    localparam bit c_SUB4 = (NK > 6);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_IW-1:0]   r_idx;
    logic [c_MW-1:0]   r_mod;
    logic [7:0]        r_rcon;

    logic [c_W-1:0]    r_fw [2];
    logic              r_fs [2];
    logic [7:0]        r_fr [2];
    logic              r_fl [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;

    logic              w_push, w_pop, w_rot, w_sub, w_last;
    logic [c_W-1:0]    w_left, w_rotated, w_word;
    logic [7:0]        w_xt;

    // Left rotation: out byte j takes in byte (j+ROT) mod BYTES
    for (genvar j = 0; j < BYTES; j++) begin : g_left
        assign w_left[j*BW +: BW] = in_word[((j + ROT) % BYTES)*BW +: BW];
    end

`ifdef KEYGEN_ROTDIR_EN
    logic [c_W-1:0] w_right;
    for (genvar j = 0; j < BYTES; j++) begin : g_right
        assign w_right[j*BW +: BW] = in_word[((j + BYTES - ROT) % BYTES)*BW +: BW];
    end
    assign w_rotated = rot_dir ? w_right : w_left;
`else
    assign w_rotated = w_left;
`endif

    assign in_ready  = (r_state == S_RUN) && (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_rot     = (r_mod == '0);
    assign w_sub     = w_rot | (c_SUB4 && (r_mod == c_MW'(4)));
    assign w_last    = (r_idx == c_IW'(c_LAST));
    assign w_word    = w_rot ? w_rotated : in_word;
    assign w_xt      = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    assign out_word  = r_fw[r_rp];
    assign out_sub   = r_fs[r_rp];
    assign out_rcon  = r_fr[r_rp];
    assign out_last  = r_fl[r_rp];

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_push && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_IDLE;
                    done        = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Word index plus a parallel mod-NK phase avoids any divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= c_IW'(NK);
            r_mod  <= '0;
            r_rcon <= 8'h01;
        end else if ((r_state == S_IDLE) && start) begin
            r_idx  <= c_IW'(NK);
            r_mod  <= '0;
            r_rcon <= 8'h01;
        end else if (w_push) begin
            r_idx <= r_idx + c_IW'(1);
            r_mod <= (r_mod == c_MW'(NK - 1)) ? '0 : r_mod + c_MW'(1);
            if (w_rot) r_rcon <= w_xt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                r_fw[k] <= '0;
                r_fs[k] <= 1'b0;
                r_fr[k] <= 8'h00;
                r_fl[k] <= 1'b0;
            end
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fw[r_wp] <= w_word;
                r_fs[r_wp] <= w_sub;
                r_fr[r_wp] <= w_rot ? r_rcon : 8'h00;
                r_fl[r_wp] <= w_last;
                r_wp       <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_keygen_rotword_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_keygen_rotword_pipe
// Brief    : Self-checking bench; NK=8 and NK=4 instances against a
//            queue-based reference model of the key-expansion word stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_keygen_rotword_pipe;

    typedef struct packed {
        logic [31:0] w;
        logic        sub;
        logic [7:0]  rcon;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, sel;
    logic        drv_start, drv_in_valid, drv_out_ready;
    logic [31:0] drv_in_word;

    logic        start_a, in_valid_a, out_ready_a, start_b, in_valid_b, out_ready_b;
    logic        in_ready_a, out_valid_a, out_sub_a, out_last_a, done_a;
    logic        in_ready_b, out_valid_b, out_sub_b, out_last_b, done_b;
    logic [31:0] out_word_a, out_word_b;
    logic [7:0]  out_rcon_a, out_rcon_b;

    logic        cur_in_ready, cur_out_valid, cur_out_sub, cur_out_last, cur_done;
    logic [31:0] cur_out_word;
    logic [7:0]  cur_out_rcon;

    assign start_a     = !sel && drv_start;
    assign in_valid_a  = !sel && drv_in_valid;
    assign out_ready_a = sel  || drv_out_ready;
    assign start_b     = sel  && drv_start;
    assign in_valid_b  = sel  && drv_in_valid;
    assign out_ready_b = !sel || drv_out_ready;

    assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign cur_out_valid = sel ? out_valid_b : out_valid_a;
    assign cur_out_sub   = sel ? out_sub_b   : out_sub_a;
    assign cur_out_last  = sel ? out_last_b  : out_last_a;
    assign cur_done      = sel ? done_b      : done_a;
    assign cur_out_word  = sel ? out_word_b  : out_word_a;
    assign cur_out_rcon  = sel ? out_rcon_b  : out_rcon_a;

    mod_keygen_rotword_pipe #(.BYTES(4), .BW(8), .NK(8), .ROT(1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_word(drv_in_word), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_word(out_word_a), .out_sub(out_sub_a),
        .out_rcon(out_rcon_a), .out_last(out_last_a), .done(done_a)
    );

    mod_keygen_rotword_pipe #(.BYTES(4), .BW(8), .NK(4), .ROT(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_word(drv_in_word), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_word(out_word_b), .out_sub(out_sub_b),
        .out_rcon(out_rcon_b), .out_last(out_last_b), .done(done_b)
    );

    int   n_vec, n_err;
    int   nk, idx;
    bit   running, draining;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Rcon for the k-th rotated word: x^(k-1) in GF(2^8) mod 0x11B
    function automatic logic [7:0] rcon_pow(input int k);
        int v = 1;
        for (int t = 1; t < k; t++) begin
            v = v * 2;
            if (v >= 256) v = v ^ 'h11B;
        end
        return v[7:0];
    endfunction

    function automatic exp_t model(input int nk_m, input int i, input logic [31:0] w);
        exp_t e;
        bit   rot = (i % nk_m) == 0;
        e.w = w;
        if (rot)
            for (int j = 0; j < 4; j++) e.w[j*8 +: 8] = w[((j + 1) % 4)*8 +: 8];
        e.sub  = rot || (nk_m > 6 && (i % nk_m) == 4);
        e.rcon = rot ? rcon_pow(i / nk_m) : 8'h00;
        e.last = (i == 4 * (nk_m + 7) - 1);
        return e;
    endfunction

    task automatic step();
        bit   exp_rdy  = running && (q.size() < 2);
        bit   exp_done = draining && (q.size() == 0);
        bit   idle_pre = !running && !draining;
        exp_t e;
        chk("in_ready", cur_in_ready, exp_rdy);
        chk("out_valid", cur_out_valid, q.size() != 0);
        chk("done", cur_done, exp_done);
        if (q.size() != 0 && drv_out_ready) begin
            e = q.pop_front();
            chk("out_word", cur_out_word, e.w);
            chk("out_sub", cur_out_sub, e.sub);
            chk("out_rcon", cur_out_rcon, e.rcon);
            chk("out_last", cur_out_last, e.last);
        end
        if (drv_in_valid && exp_rdy) begin
            q.push_back(model(nk, idx, drv_in_word));
            if (idx == 4 * (nk + 7) - 1) begin
                running  = 1'b0;
                draining = 1'b1;
            end
            idx++;
        end
        if (exp_done) draining = 1'b0;
        if (drv_start && idle_pre) begin
            running = 1'b1;
            idx     = nk;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int budget);
        for (int c = 0; c < budget && (running || draining); c++) begin
            drv_in_valid  = ($urandom % 4) != 0;
            drv_in_word   = $urandom;
            drv_out_ready = ($urandom % 4) != 0;
            drv_start     = ($urandom % 16) == 0;
            step();
        end
        drv_start     = 1'b0;
        drv_in_valid  = 1'b0;
        drv_out_ready = 1'b1;
        chk("run_complete", {30'd0, running, draining}, 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; sel = 1'b0; nk = 8; idx = 0;
        running = 1'b0; draining = 1'b0;
        drv_start = 1'b0; drv_in_valid = 1'b0; drv_out_ready = 1'b1; drv_in_word = '0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_a", out_valid_a, 0);
        chk("rst_in_ready_a", in_ready_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_out_word_a", out_word_a, 0);
        chk("rst_out_rcon_a", out_rcon_a, 0);
        chk("rst_out_sub_a", out_sub_a, 0);
        chk("rst_out_last_a", out_last_a, 0);
        chk("rst_out_valid_b", out_valid_b, 0);
        chk("rst_in_ready_b", in_ready_b, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        step();

        // NK=8: directed first words, then randomized remainder of the run
        drv_start = 1'b1; step(); drv_start = 1'b0;
        drv_in_valid = 1'b1; drv_in_word = 32'h0C0D0E0F; step();
        chk("first_valid", cur_out_valid, 1);
        chk("first_word", cur_out_word, 32'h0F0C0D0E);
        chk("first_sub", cur_out_sub, 1);
        chk("first_rcon", cur_out_rcon, 8'h01);
        for (int k = 0; k < 3; k++) begin
            drv_in_word = $urandom;
            step();
            chk("pass_sub", cur_out_sub, 0);
            chk("pass_rcon", cur_out_rcon, 0);
        end
        drv_in_word = 32'h11223344; step();
        drv_in_valid = 1'b0;
        chk("i12_word", cur_out_word, 32'h11223344);
        chk("i12_sub", cur_out_sub, 1);
        chk("i12_rcon", cur_out_rcon, 8'h00);
        run_random(2000);
        drv_in_valid = 1'b1;
        repeat (3) step();
        drv_in_valid = 1'b0;

        // Backpressure: exactly two words buffered, then released in order
        drv_start = 1'b1; step(); drv_start = 1'b0;
        drv_out_ready = 1'b0; drv_in_valid = 1'b1;
        repeat (4) begin
            drv_in_word = $urandom;
            step();
        end
        drv_in_valid = 1'b0; drv_out_ready = 1'b1;
        repeat (3) step();

        // Mid-run reset with one word buffered
        drv_in_valid = 1'b1; drv_in_word = $urandom; step();
        drv_in_valid = 1'b0; drv_out_ready = 1'b0;
        chk("pre_rst_valid", cur_out_valid, 1);
        rst_a = 1'b0;
        #1;
        chk("midrst_out_valid", cur_out_valid, 0);
        chk("midrst_in_ready", cur_in_ready, 0);
        chk("midrst_done", cur_done, 0);
        q.delete(); running = 1'b0; draining = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1; drv_out_ready = 1'b1;
        step();
        drv_start = 1'b1; step(); drv_start = 1'b0;
        drv_in_valid = 1'b1; drv_in_word = $urandom; step();
        drv_in_valid = 1'b0;
        chk("restart_sub", cur_out_sub, 1);
        chk("restart_rcon", cur_out_rcon, 8'h01);
        run_random(2000);

        // NK=4 instance: full randomized run covering the 0x1B/0x36 Rcon wrap
        sel = 1'b1; nk = 4;
        step();
        drv_start = 1'b1; step(); drv_start = 1'b0;
        run_random(2000);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
